// File: rtl/alu_arbiter.sv
// Round-robin arbiter that time-shares one multi-cycle ALU among four requesters.
// It sequences each transaction through grant, start pulse, busy window, ack pulse and release.
module alu_arbiter #(
  parameter int LATENCY = 2,
  parameter int CNT_W   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       alu_start,
  output logic       busy,
  output logic [3:0] ack
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       ptr_reg;

  logic [1:0] cand [4];
  logic [3:0] hit;
  logic [1:0] winner;

  // Scan order starts at the round-robin pointer and wraps modulo 4.
  for (genvar gi = 0; gi < 4; gi++) begin : g_scan
    assign cand[gi] = ptr_reg + 2'(gi);
    assign hit[gi]  = req[cand[gi]];
  end

  always_comb begin
    winner = ptr_reg;
    for (int i = 3; i >= 0; i--) begin
      if (hit[i]) begin
        winner = cand[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ptr_reg   <= 2'd0;
      grant     <= 4'b0000;
      sel       <= 2'd0;
      alu_start <= 1'b0;
      ack       <= 4'b0000;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|req) begin
            grant     <= 4'b0001 << winner;
            sel       <= winner;
            alu_start <= 1'b1;
            cnt_reg   <= CNT_W'(LATENCY - 1);
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          alu_start <= 1'b0;
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end else begin
            ack       <= grant;
            state_reg <= RELEASE;
          end
        end
        RELEASE: begin
          // The owner drops to lowest priority for the next arbitration.
          ack       <= 4'b0000;
          grant     <= 4'b0000;
          ptr_reg   <= sel + 2'd1;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy = |grant;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: expected acks queued at stimulus time, popped by a monitor.
// A second instance with LATENCY=1 covers the shortest transaction.
module tb_alu_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req   = 4'b0000;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       alu_start;
  logic       busy;
  logic [3:0] ack;

  logic [3:0] req1 = 4'b0000;
  logic [3:0] grant1;
  logic [1:0] sel1;
  logic       start1;
  logic       busy1;
  logic [3:0] ack1;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];
  logic [3:0] exp1_q[$];
  logic [3:0] e0;
  logic [3:0] e1;

  always #5 clock = ~clock;

  alu_arbiter #(.LATENCY(2), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .req(req), .grant(grant), .sel(sel),
    .alu_start(alu_start), .busy(busy), .ack(ack)
  );

  alu_arbiter #(.LATENCY(1), .CNT_W(4)) dut1 (
    .clock(clock), .reset(reset), .req(req1), .grant(grant1), .sel(sel1),
    .alu_start(start1), .busy(busy1), .ack(ack1)
  );

  // Monitor: per-cycle invariants and ack scoreboard for both instances.
  always @(negedge clock) begin
    if (reset) begin
      checks++;
      if (!$onehot0(grant) || ((ack & ~grant) != 4'b0) || (alu_start && ack != 4'b0) || (busy !== (|grant))) begin
        errors++;
        $display("FAIL invariant: grant=%b ack=%b alu_start=%b busy=%b", grant, ack, alu_start, busy);
      end
      checks++;
      if (!$onehot0(grant1) || ((ack1 & ~grant1) != 4'b0) || (start1 && ack1 != 4'b0) || (busy1 !== (|grant1))) begin
        errors++;
        $display("FAIL invariant_l1: grant=%b ack=%b alu_start=%b busy=%b", grant1, ack1, start1, busy1);
      end
      if (ack !== 4'b0000) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack: got %b expected none", ack);
        end else begin
          e0 = exp_q.pop_front();
          if (ack !== e0) begin
            errors++;
            $display("FAIL ack: got %b expected %b", ack, e0);
          end else begin
            $display("txn ack=%b sel=%0d", ack, sel);
          end
        end
      end
      if (ack1 !== 4'b0000) begin
        checks++;
        if (exp1_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack_l1: got %b expected none", ack1);
        end else begin
          e1 = exp1_q.pop_front();
          if (ack1 !== e1) begin
            errors++;
            $display("FAIL ack_l1: got %b expected %b", ack1, e1);
          end else begin
            $display("txn l1 ack=%b sel=%0d", ack1, sel1);
          end
        end
      end
    end
  end

  task automatic wait_grant;
    int n;
    n = 0;
    while (grant === 4'b0000 && n < 20) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic wait_ack;
    int n;
    n = 0;
    while (ack === 4'b0000 && n < 20) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (ack === 4'b0000) begin
      errors++;
      $display("FAIL ack_timeout: got %b expected nonzero", ack);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    req   = 4'b0000;
    req1  = 4'b0000;
    repeat (3) @(negedge clock);
    checks++;
    if (grant !== 4'b0 || sel !== 2'd0 || alu_start !== 1'b0 || ack !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: got grant=%b sel=%0d start=%b ack=%b busy=%b expected all 0", grant, sel, alu_start, ack, busy);
    end
    checks++;
    if (grant1 !== 4'b0 || start1 !== 1'b0 || ack1 !== 4'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_l1: got grant=%b start=%b ack=%b busy=%b expected all 0", grant1, start1, ack1, busy1);
    end
    #2 reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_single;
    req = 4'b0100;
    exp_q.push_back(4'b0100);
    wait_grant();
    checks++;
    if (grant !== 4'b0100 || sel !== 2'd2 || alu_start !== 1'b1 || ack !== 4'b0) begin
      errors++;
      $display("FAIL single_c1: got grant=%b sel=%0d start=%b ack=%b expected 0100/2/1/0000", grant, sel, alu_start, ack);
    end
    @(negedge clock);
    checks++;
    if (grant !== 4'b0100 || alu_start !== 1'b0 || ack !== 4'b0) begin
      errors++;
      $display("FAIL single_c2: got grant=%b start=%b ack=%b expected 0100/0/0000", grant, alu_start, ack);
    end
    @(negedge clock);
    checks++;
    if (grant !== 4'b0100 || ack !== 4'b0100) begin
      errors++;
      $display("FAIL single_c3: got grant=%b ack=%b expected 0100/0100", grant, ack);
    end
    req = 4'b0000;
    @(negedge clock);
    checks++;
    if (grant !== 4'b0 || busy !== 1'b0 || ack !== 4'b0) begin
      errors++;
      $display("FAIL single_release: got grant=%b busy=%b ack=%b expected 0000/0/0000", grant, busy, ack);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] rr_exp [5];
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset = 1'b0;
    #3 reset = 1'b1;
    @(negedge clock);
    for (int k = 0; k < 5; k++) exp_q.push_back(rr_exp[k]);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant();
      checks++;
      if (grant !== rr_exp[k]) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b expected %b", k, grant, rr_exp[k]);
      end
      if (k == 4) req = 4'b0000;
      wait_ack();
      @(negedge clock);
    end
  endtask

  task automatic test_priority;
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    req = 4'b1001;
    wait_grant();
    checks++;
    if (grant !== 4'b1000 || sel !== 2'd3) begin
      errors++;
      $display("FAIL prio_first: got grant=%b sel=%0d expected 1000/3", grant, sel);
    end
    wait_ack();
    req = 4'b0001;
    @(negedge clock);
    wait_grant();
    checks++;
    if (grant !== 4'b0001 || sel !== 2'd0) begin
      errors++;
      $display("FAIL prio_second: got grant=%b sel=%0d expected 0001/0", grant, sel);
    end
    wait_ack();
    req = 4'b0000;
    @(negedge clock);
  endtask

  task automatic test_drop_mid_op;
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    req = 4'b0010;
    wait_grant();
    checks++;
    if (grant !== 4'b0010 || sel !== 2'd1) begin
      errors++;
      $display("FAIL drop_grant: got grant=%b sel=%0d expected 0010/1", grant, sel);
    end
    @(negedge clock);
    req = 4'b0100;
    @(negedge clock);
    checks++;
    if (grant !== 4'b0010 || sel !== 2'd1 || ack !== 4'b0010) begin
      errors++;
      $display("FAIL drop_hold: got grant=%b sel=%0d ack=%b expected 0010/1/0010", grant, sel, ack);
    end
    @(negedge clock);
    wait_grant();
    checks++;
    if (grant !== 4'b0100 || sel !== 2'd2) begin
      errors++;
      $display("FAIL drop_next: got grant=%b sel=%0d expected 0100/2", grant, sel);
    end
    wait_ack();
    req = 4'b0000;
    @(negedge clock);
  endtask

  task automatic test_async_reset;
    req = 4'b0100;
    wait_grant();
    checks++;
    if (grant !== 4'b0100) begin
      errors++;
      $display("FAIL areset_grant: got %b expected 0100", grant);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (grant !== 4'b0 || sel !== 2'd0 || alu_start !== 1'b0 || ack !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL areset_now: got grant=%b sel=%0d start=%b ack=%b busy=%b expected all 0", grant, sel, alu_start, ack, busy);
    end
    req = 4'b0000;
    @(negedge clock);
    checks++;
    if (grant !== 4'b0 || ack !== 4'b0) begin
      errors++;
      $display("FAIL areset_hold: got grant=%b ack=%b expected 0000/0000", grant, ack);
    end
    #3 reset = 1'b1;
    @(negedge clock);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b1000);
    req = 4'b1010;
    wait_grant();
    checks++;
    if (grant !== 4'b0010 || sel !== 2'd1) begin
      errors++;
      $display("FAIL areset_ptr: got grant=%b sel=%0d expected 0010/1", grant, sel);
    end
    wait_ack();
    req = 4'b1000;
    @(negedge clock);
    wait_grant();
    checks++;
    if (grant !== 4'b1000) begin
      errors++;
      $display("FAIL areset_next: got %b expected 1000", grant);
    end
    wait_ack();
    req = 4'b0000;
    @(negedge clock);
  endtask

  task automatic test_latency1;
    int n;
    exp1_q.push_back(4'b0001);
    req1 = 4'b0001;
    n = 0;
    while (grant1 === 4'b0000 && n < 20) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (grant1 !== 4'b0001 || start1 !== 1'b1 || ack1 !== 4'b0) begin
      errors++;
      $display("FAIL l1_c1: got grant=%b start=%b ack=%b expected 0001/1/0000", grant1, start1, ack1);
    end
    @(negedge clock);
    checks++;
    if (grant1 !== 4'b0001 || start1 !== 1'b0 || ack1 !== 4'b0001) begin
      errors++;
      $display("FAIL l1_c2: got grant=%b start=%b ack=%b expected 0001/0/0001", grant1, start1, ack1);
    end
    req1 = 4'b0000;
    @(negedge clock);
    checks++;
    if (grant1 !== 4'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL l1_release: got grant=%b busy=%b expected 0000/0", grant1, busy1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_priority();
    test_drop_mid_op();
    test_async_reset();
    test_latency1();
    repeat (2) @(negedge clock);
    checks++;
    if (exp_q.size() != 0 || exp1_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending acks expected 0/0", exp_q.size(), exp1_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
